baud_clock_handler: RTL and testbench

//  Baud-rate timing generator for the UART link of the VGA project. From one

---
 rtl/baud_clock_handler.sv | 150 +++++++++++++++
 tb/tb_baud_clock_handler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/baud_clock_handler.sv
// -----------------------------------------------------------------------------
// baud_clock_handler
//
// Baud-rate timing generator for the UART link. From the system clock it
// derives a 16x-oversample strobe (RX sampling) and a 1x bit strobe (TX
// shifting) for a baud rate selected at run time through a 3-bit code.
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   DIV_W       width of the 16x divider counter
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   baud        in   [2:0] rate code: 0=2400 1=4800 2=9600 3=19200 4=38400
//                    5=57600 6=115200 7=reserved (ignored)
//   baud_ready  in   a 0->1 transition loads baud as the active selection
//   clk_16bd    out  one-clk strobe at 16 x baud
//   clk_bd      out  one-clk strobe at 1 x baud (always with a clk_16bd strobe)
//   locked      out  only when BAUD_LOCKED_EN is defined: 0 after reset or an
//                    accepted load, 1 from the cycle after the first clk_bd
//
// Optional feature macro: BAUD_LOCKED_EN (adds the locked output).
// -----------------------------------------------------------------------------
module baud_clock_handler #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned DIV_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud,
    input  logic       baud_ready,
    output logic       clk_16bd,
    output logic       clk_bd
`ifdef BAUD_LOCKED_EN
    ,
    output logic       locked
`endif
);

    localparam logic [2:0] CodeReserved = 3'b111;
    localparam logic [2:0] CodeDefault  = 3'b010;

    function automatic longint unsigned rate_of(input int unsigned code);
        longint unsigned r;
        case (code)
            0:       r = 64'd2400;
            1:       r = 64'd4800;
            2:       r = 64'd9600;
            3:       r = 64'd19200;
            4:       r = 64'd38400;
            5:       r = 64'd57600;
            6:       r = 64'd115200;
            default: r = 64'd9600;
        endcase
        return r;
    endfunction

    // Round-half-up of CLK_FREQ / (16 * rate).
    function automatic longint unsigned div16_of(input int unsigned code);
        longint unsigned r;
        r = rate_of(code);
        return (64'(CLK_FREQ) + 64'd8 * r) / (64'd16 * r);
    endfunction

    localparam longint unsigned DivMax = (64'd1 << DIV_W) - 64'd1;

    for (genvar g = 0; g < 7; g++) begin : g_div_check
        if (div16_of(g) < 64'd1 || div16_of(g) > DivMax) begin : g_bad
            $error("baud_clock_handler: divider for code %0d out of range", g);
        end
    end

    localparam logic [DIV_W-1:0] Div0 = DIV_W'(div16_of(0));
    localparam logic [DIV_W-1:0] Div1 = DIV_W'(div16_of(1));
    localparam logic [DIV_W-1:0] Div2 = DIV_W'(div16_of(2));
    localparam logic [DIV_W-1:0] Div3 = DIV_W'(div16_of(3));
    localparam logic [DIV_W-1:0] Div4 = DIV_W'(div16_of(4));
    localparam logic [DIV_W-1:0] Div5 = DIV_W'(div16_of(5));
    localparam logic [DIV_W-1:0] Div6 = DIV_W'(div16_of(6));

    logic [2:0]       sel_q;
    logic             br_q;
    logic [DIV_W-1:0] cnt16_q;
    logic [3:0]       cnt_bit_q;
    logic [DIV_W-1:0] div_sel;
    logic             load;
    logic             wrap;

    always_comb begin
        div_sel = Div2;
        case (sel_q)
            3'd0:    div_sel = Div0;
            3'd1:    div_sel = Div1;
            3'd2:    div_sel = Div2;
            3'd3:    div_sel = Div3;
            3'd4:    div_sel = Div4;
            3'd5:    div_sel = Div5;
            3'd6:    div_sel = Div6;
            default: div_sel = Div2;
        endcase
    end

    // Only a rising edge of baud_ready with a valid code is a load.
    assign load = baud_ready && !br_q && (baud != CodeReserved);
    // >= rather than == so the counter can never run past its terminal value.
    assign wrap = (cnt16_q >= (div_sel - DIV_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q     <= CodeDefault;
            br_q      <= 1'b0;
            cnt16_q   <= '0;
            cnt_bit_q <= '0;
            clk_16bd  <= 1'b0;
            clk_bd    <= 1'b0;
        end else begin
            br_q <= baud_ready;
            if (load) begin
                sel_q     <= baud;
                cnt16_q   <= '0;
                cnt_bit_q <= '0;
                clk_16bd  <= 1'b0;
                clk_bd    <= 1'b0;
            end else if (wrap) begin
                cnt16_q   <= '0;
                cnt_bit_q <= cnt_bit_q + 4'd1;
                clk_16bd  <= 1'b1;
                clk_bd    <= (cnt_bit_q == 4'd15);
            end else begin
                cnt16_q   <= cnt16_q + DIV_W'(1);
                clk_16bd  <= 1'b0;
                clk_bd    <= 1'b0;
            end
        end
    end

`ifdef BAUD_LOCKED_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked <= 1'b0;
        end else if (load) begin
            locked <= 1'b0;
        end else if (clk_bd) begin
            locked <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_baud_clock_handler.sv
module tb_baud_clock_handler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] baud = 3'b010;
    logic       baud_ready = 1'b0;
    logic       clk_16bd;
    logic       clk_bd;
`ifdef BAUD_LOCKED_EN
    logic       locked;
`endif

    baud_clock_handler #(
        .CLK_FREQ (1_843_200),
        .DIV_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud       (baud),
        .baud_ready (baud_ready),
        .clk_16bd   (clk_16bd),
        .clk_bd     (clk_bd)
`ifdef BAUD_LOCKED_EN
        ,
        .locked     (locked)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: elapsed edges since the last restart and the period.
    int rates[7] = '{2400, 4800, 9600, 19200, 38400, 57600, 115200};
    int m_t;
    int m_d;
    bit m_br_prev;
    bit m_locked;
    bit m_bd_prev;
    bit exp16;
    bit expbd;

    function automatic int div_of(input int code);
        return (1843200 + 8 * rates[code]) / (16 * rates[code]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t       = 0;
        m_d       = div_of(2);
        m_br_prev = 1'b0;
        m_locked  = 1'b0;
        m_bd_prev = 1'b0;
        exp16     = 1'b0;
        expbd     = 1'b0;
    endtask

    task automatic model_edge();
        bit accept;
        accept    = baud_ready && !m_br_prev && (baud != 3'b111);
        m_br_prev = baud_ready;
        if (accept) begin
            m_d      = div_of(int'(baud));
            m_t      = 0;
            m_locked = 1'b0;
        end else begin
            if (m_bd_prev) m_locked = 1'b1;
            m_t++;
        end
        exp16     = (m_t > 0) && (m_t % m_d == 0);
        expbd     = (m_t > 0) && (m_t % (16 * m_d) == 0);
        m_bd_prev = expbd;
    endtask

    // Drive inputs just after an edge, advance one clock, compare against model.
    task automatic step(input bit br, input logic [2:0] code);
        baud_ready = br;
        baud       = code;
        @(posedge clk);
        model_edge();
        #1;
        check("strobes", {30'd0, clk_16bd, clk_bd}, {30'd0, exp16, expbd});
`ifdef BAUD_LOCKED_EN
        check("locked", {31'd0, locked}, {31'd0, m_locked});
`endif
    endtask

    // Step until clk_16bd (or clk_bd) is seen; hold=1 keeps baud_ready high
    // while scrambling baud, which must be ignored.
    task automatic run_until(input bit want_bd, input bit hold, input logic [2:0] code,
                             output int n);
        bit hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < 1000) begin
            step(hold, hold ? 3'($urandom_range(0, 7)) : code);
            n++;
            hit = want_bd ? clk_bd : clk_16bd;
        end
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: no strobe within %0d clks (want_bd=%0d)", n, want_bd);
        end
    endtask

    typedef struct {
        logic [2:0] code;
        int         first16;
        int         firstbd;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n1;
        int n2;

        tbl[0] = '{3'd2, 12, 192};
        tbl[1] = '{3'd1, 24, 384};
        tbl[2] = '{3'd6, 1, 16};
        tbl[3] = '{3'd0, 48, 768};
        tbl[4] = '{3'd5, 2, 32};
        tbl[5] = '{3'd4, 3, 48};
        tbl[6] = '{3'd3, 6, 96};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_strobes", {30'd0, clk_16bd, clk_bd}, 32'd0);
`ifdef BAUD_LOCKED_EN
        check("reset_locked", {31'd0, locked}, 32'd0);
`endif
        model_reset();
        rst = 1'b1;

        // Default 9600 without any load
        run_until(1'b0, 1'b0, 3'b010, n1);
        check("default_first16", n1, 12);
        run_until(1'b1, 1'b0, 3'b010, n2);
        check("default_firstbd", n1 + n2, 192);
        run_until(1'b0, 1'b0, 3'b010, n1);
        check("default_period16", n1, 12);

        // Table of loads
        for (int i = 0; i < 7; i++) begin
            step(1'b0, tbl[i].code);
            step(1'b1, tbl[i].code);
            check("load_cycle_quiet", {30'd0, clk_16bd, clk_bd}, 32'd0);
            run_until(1'b0, 1'b1, tbl[i].code, n1);
            check("load_first16", n1, tbl[i].first16);
            run_until(1'b1, 1'b1, tbl[i].code, n2);
            check("load_firstbd", n1 + n2, tbl[i].firstbd);
        end

        // Reserved code on a load edge: period stays at 6, no restart
        step(1'b0, 3'd3);
        step(1'b1, 3'b111);
        run_until(1'b0, 1'b0, 3'd3, n1);
        run_until(1'b0, 1'b0, 3'd3, n1);
        check("reserved_period", n1, 6);

        // Asynchronous reset while clk_16bd is high (115200, strobe every clk)
        step(1'b0, 3'd6);
        step(1'b1, 3'd6);
        repeat (20) step(1'b0, 3'd6);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_strobes", {30'd0, clk_16bd, clk_bd}, 32'd0);
`ifdef BAUD_LOCKED_EN
        check("async_rst_locked", {31'd0, locked}, 32'd0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_until(1'b0, 1'b0, 3'd6, n1);
        check("resume_first16", n1, 12);
        run_until(1'b1, 1'b0, 3'd6, n2);
        check("resume_firstbd", n1 + n2, 192);
        step(1'b0, 3'd6);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 4, 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
